// File: rtl/rv_branch_predict_unit.sv
// Branch predictor: direct-mapped BHT/BTB with 2-bit counters, execute-stage branch
// resolution, mispredict detection and saturating event statistics.
module rv_branch_predict_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   fetch_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic              branch,
    input  logic              jump,
    input  logic              is_jalr,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   pc_current,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    output logic [XLEN-1:0]   pc_next,
    output logic              pc_taken,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);
    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic              valid_q  [BHT_DEPTH];
    logic [TAG_W-1:0]  tag_q    [BHT_DEPTH];
    logic [XLEN-1:0]   target_q [BHT_DEPTH];
    logic [1:0]        ctr_q    [BHT_DEPTH];
    logic [STAT_W-1:0] stat_br_q, stat_mis_q;

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[XLEN-1:IDX_W+2];
    assign u_idx = pc_current[IDX_W+1:2];
    assign u_tag = pc_current[XLEN-1:IDX_W+2];

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken  = f_hit && ctr_q[f_idx][1];
    assign pred_target = pred_taken ? target_q[f_idx] : fetch_pc + PC_STEP;

    logic            cond;
    logic            f3_legal;
    logic [XLEN-1:0] target;

    always_comb begin
        cond     = 1'b0;
        f3_legal = 1'b1;
        unique case (funct3)
            3'b000:  cond = (rs1_data == rs2_data);
            3'b001:  cond = (rs1_data != rs2_data);
            3'b100:  cond = ($signed(rs1_data) < $signed(rs2_data));
            3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond = (rs1_data < rs2_data);
            3'b111:  cond = (rs1_data >= rs2_data);
            default: f3_legal = 1'b0;
        endcase
    end

    always_comb begin
        target = pc_current + imm;
        if (is_jalr) begin
            target     = rs1_data + imm;
            target[0]  = 1'b0;
        end
    end

    assign pc_taken   = ex_valid && ((branch && cond) || jump);
    assign pc_next    = pc_taken ? target : pc_current + PC_STEP;
    assign mispredict = ex_valid && ((ex_pred_taken != pc_taken) ||
                                     (pc_taken && (ex_pred_target != pc_next)));

    logic       wr_en;
    logic [1:0] wr_ctr;

    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // JALR targets are data-dependent, so only JAL and conditional branches are installed.
    always_comb begin
        wr_en  = 1'b0;
        wr_ctr = ctr_q[u_idx];
        if (ex_valid) begin
            if (jump) begin
                if (!is_jalr) begin
                    wr_en  = 1'b1;
                    wr_ctr = 2'b11;
                end
            end else if (branch && f3_legal) begin
                wr_en = 1'b1;
                if (!u_hit) begin
                    wr_ctr = pc_taken ? 2'b10 : 2'b01;
                end else if (pc_taken) begin
                    if (ctr_q[u_idx] != 2'b11) wr_ctr = ctr_q[u_idx] + 2'b01;
                end else begin
                    if (ctr_q[u_idx] != 2'b00) wr_ctr = ctr_q[u_idx] - 2'b01;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= target;
                ctr_q[u_idx]    <= wr_ctr;
            end
            if (ex_valid && (branch || jump) && (stat_br_q != '1)) begin
                stat_br_q <= stat_br_q + 1'b1;
            end
            if (mispredict && (stat_mis_q != '1)) begin
                stat_mis_q <= stat_mis_q + 1'b1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_rv_branch_predict_unit.sv
// Self-checking bench: directed vectors plus randomized traffic against a table-level
// reference model of the predictor, resolver and statistics counters.
module tb_rv_branch_predict_unit;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned IDXW   = $clog2(DEPTH);
    localparam int unsigned STAT_W = 4;
    localparam int unsigned STAT_MAX = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [XLEN-1:0]   fetch_pc;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
    logic              ex_valid, branch, jump, is_jalr;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   pc_current, rs1_data, rs2_data, imm;
    logic              ex_pred_taken;
    logic [XLEN-1:0]   ex_pred_target;
    logic [XLEN-1:0]   pc_next;
    logic              pc_taken, mispredict;
    logic [STAT_W-1:0] stat_branches, stat_mispredicts;

    rv_branch_predict_unit #(
        .XLEN      (XLEN),
        .BHT_DEPTH (DEPTH),
        .STAT_W    (STAT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_pc         (fetch_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .branch           (branch),
        .jump             (jump),
        .is_jalr          (is_jalr),
        .funct3           (funct3),
        .pc_current       (pc_current),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .imm              (imm),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .pc_next          (pc_next),
        .pc_taken         (pc_taken),
        .mispredict       (mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_valid  [DEPTH];
    logic [31:0] m_tagv   [DEPTH];
    logic [31:0] m_target [DEPTH];
    int          m_ctr    [DEPTH];
    int          m_sb, m_sm;

    bit          e_taken, e_mis;
    logic [31:0] e_tgt, e_next;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] m_tag(input logic [31:0] pc);
        return pc >> (2 + IDXW);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        int i = m_idx(pc);
        return m_valid[i] && (m_tagv[i] == m_tag(pc)) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
        return m_pred(pc) ? m_target[m_idx(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_sb = 0;
        m_sm = 0;
    endtask

    task automatic model_resolve();
        bit cond;
        case (funct3)
            3'd0: cond = (rs1_data == rs2_data);
            3'd1: cond = (rs1_data != rs2_data);
            3'd4: cond = ($signed(rs1_data) < $signed(rs2_data));
            3'd5: cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'd6: cond = (rs1_data < rs2_data);
            3'd7: cond = (rs1_data >= rs2_data);
            default: cond = 1'b0;
        endcase
        e_tgt   = is_jalr ? ((rs1_data + imm) & ~32'd1) : (pc_current + imm);
        e_taken = ex_valid && ((branch && cond) || jump);
        e_next  = e_taken ? e_tgt : pc_current + 32'd4;
        e_mis   = ex_valid && ((ex_pred_taken != e_taken) ||
                               (e_taken && (ex_pred_target != e_next)));
    endtask

    task automatic settle();
        #1;
        model_resolve();
        check("pred_taken",  pred_taken,  m_pred(fetch_pc));
        check("pred_target", pred_target, m_pred_tgt(fetch_pc));
        check("pc_taken",    pc_taken,    e_taken);
        check("pc_next",     pc_next,     e_next);
        check("mispredict",  mispredict,  e_mis);
        check("stat_br",     stat_branches,    m_sb);
        check("stat_mis",    stat_mispredicts, m_sm);
    endtask

    task automatic tick();
        int i;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            i = m_idx(pc_current);
            if (ex_valid && (branch || jump) && m_sb < int'(STAT_MAX)) m_sb++;
            if (e_mis && m_sm < int'(STAT_MAX)) m_sm++;
            if (ex_valid && jump && !is_jalr) begin
                m_valid[i] = 1'b1; m_tagv[i] = m_tag(pc_current);
                m_target[i] = e_tgt; m_ctr[i] = 3;
            end else if (ex_valid && branch && !jump && funct3 != 3'd2 && funct3 != 3'd3) begin
                if (m_valid[i] && m_tagv[i] == m_tag(pc_current))
                    m_ctr[i] = e_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                       : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                else
                    m_ctr[i] = e_taken ? 2 : 1;
                m_valid[i] = 1'b1; m_tagv[i] = m_tag(pc_current); m_target[i] = e_tgt;
            end
        end
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; branch = 0; jump = 0; is_jalr = 0; funct3 = 3'd0;
        pc_current = 32'h0; rs1_data = 0; rs2_data = 0; imm = 0;
        ex_pred_taken = 0; ex_pred_target = 0; fetch_pc = 32'h0;
    endtask

    task automatic set_branch(input logic [2:0] f3, input logic [31:0] pc,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] im);
        idle();
        ex_valid = 1; branch = 1; funct3 = f3; pc_current = pc;
        rs1_data = a; rs2_data = b; imm = im;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] rand_pc();
        return 32'h1000 + ($urandom_range(0, 3) << (2 + IDXW)) +
               ($urandom_range(0, DEPTH - 1) << 2);
    endfunction

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;

        // Reset state
        fetch_pc = 32'h100;
        settle();
        check("rst_pred_taken",  pred_taken,  1'b0);
        check("rst_pred_target", pred_target, 32'h104);
        tick();

        // BLTU: unsigned 0xFFFFFFFF < 1 is false
        set_branch(3'b110, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h40);
        settle();
        check("bltu_taken", pc_taken, 1'b0);
        check("bltu_next",  pc_next,  32'h204);
        check("bltu_mis",   mispredict, 1'b0);
        tick();

        // BLT: signed -1 < 1 is true
        set_branch(3'b100, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h40);
        settle();
        check("blt_taken", pc_taken, 1'b1);
        check("blt_next",  pc_next,  32'h240);
        check("blt_mis",   mispredict, 1'b1);
        tick();
        idle();
        fetch_pc = 32'h200;
        settle();
        check("blt_pred_taken",  pred_taken,  1'b1);
        check("blt_pred_target", pred_target, 32'h240);
        tick();

        // Counter walk at 0x300: four taken, one not taken, stays predicted taken
        for (int k = 0; k < 5; k++) begin
            set_branch(3'b000, 32'h300, 32'h5, (k < 4) ? 32'h5 : 32'h6, 32'h40);
            fetch_pc = 32'h300;
            settle();
            tick();
            idle();
            fetch_pc = 32'h300;
            settle();
            check("walk_pred_taken", pred_taken, 1'b1);
            tick();
        end
        // One more not-taken drops the counter to weakly not-taken
        set_branch(3'b000, 32'h300, 32'h5, 32'h6, 32'h40);
        settle();
        tick();
        idle();
        fetch_pc = 32'h300;
        settle();
        check("walk_pred_nt", pred_taken, 1'b0);
        tick();
        // Restore a taken state for the JALR test
        set_branch(3'b000, 32'h300, 32'h5, 32'h5, 32'h40);
        settle();
        tick();

        // JALR at 0x300 must not touch the entry there
        idle();
        ex_valid = 1; jump = 1; is_jalr = 1; pc_current = 32'h300;
        rs1_data = 32'h1003; imm = 32'h4;
        settle();
        check("jalr_next", pc_next, 32'h1006);
        check("jalr_mis",  mispredict, 1'b1);
        tick();
        idle();
        fetch_pc = 32'h300;
        settle();
        check("jalr_entry_taken",  pred_taken,  1'b1);
        check("jalr_entry_target", pred_target, 32'h340);
        tick();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            int kind;
            idle();
            rst_n = ($urandom_range(0, 59) != 0);
            kind = int'($urandom_range(0, 9));
            pc_current = rand_pc();
            rs1_data = rand_operand();
            rs2_data = ($urandom_range(0, 3) == 0) ? rs1_data : rand_operand();
            imm = ($urandom_range(0, 255) << 1) - 32'd256;
            funct3 = 3'($urandom_range(0, 7));
            ex_valid = 1;
            case (kind)
                0, 1, 2, 3, 4, 5: branch = 1;
                6: jump = 1;
                7: begin jump = 1; is_jalr = 1; end
                8: ;
                default: begin ex_valid = 0; branch = 1; end
            endcase
            if ($urandom_range(0, 1) == 0) begin
                ex_pred_taken  = m_pred(pc_current);
                ex_pred_target = m_pred_tgt(pc_current);
            end else begin
                ex_pred_taken  = 1'($urandom_range(0, 1));
                ex_pred_target = ($urandom_range(0, 1) == 0) ? pc_current + imm : $urandom();
            end
            fetch_pc = ($urandom_range(0, 2) == 0) ? pc_current : rand_pc();
            settle();
            tick();
        end
        rst_n = 1;

        // Statistics saturation: 19 mispredicts into a 4-bit counter
        idle();
        rst_n = 0;
        settle();
        tick();
        rst_n = 1;
        for (int k = 0; k < (1 << STAT_W) + 3; k++) begin
            idle();
            ex_valid = 1; ex_pred_taken = 1; ex_pred_target = 32'h44;
            settle();
            tick();
        end
        idle();
        settle();
        check("stat_mis_sat", stat_mispredicts, 4'hF);
        tick();

        // Reset wins over a simultaneous update
        set_branch(3'b000, 32'h300, 32'h1, 32'h1, 32'h40);
        rst_n = 0;
        settle();
        tick();
        rst_n = 1;
        idle();
        fetch_pc = 32'h300;
        settle();
        check("rst_upd_pred",     pred_taken, 1'b0);
        check("rst_upd_stat_mis", stat_mispredicts, 4'h0);
        check("rst_upd_stat_br",  stat_branches, 4'h0);
        tick();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
